led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern generator for the board top level: it turns the slide switches into a selected LED animation. Switches are synchronised and debounced, and a programmable prescaler sets the pattern step rate. It offers five patterns of width LED_W plus switch passthrough. Mode changes are glitch-free and land on step boundaries, and a freeze switch holds the current frame.

## Interface
- LED_W, 4: LED count / pattern width; legal 2..16.
- TICK_DIV, 25_000_000: clock cycles per pattern step; at least 2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a switch change; at least 1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- SW  in  4  switches: SW[2:0] select the mode; SW[3] is freeze.
- LED  out  LED_W  registered LED drive.
- mode  out  3  currently active mode (debug).

## Operation
- Input conditioning:
  - SW passes through a 2-flop synchroniser to give sw_sync.
  - The debounced value sw_db updates when sw_sync has differed from sw_db for DEBOUNCE_CYCLES consecutive cycles.
  - A return to the old value before that count completes restarts the counter.
- Prescaler: a counter runs 0..TICK_DIV-1 and pulses `tick` for one cycle at TICK_DIV-1. It runs continuously and ignores freeze.
- Mode register: on `tick`, if sw_db[2:0] != mode, then mode <= sw_db[2:0] and the pattern state is loaded with the new mode's seed. A mode change applies even while frozen.
- Pattern advance: on `tick` with no mode change and sw_db[3]=0, the state steps once. When sw_db[3]=1 the state holds.
- Modes, with state pat[LED_W-1:0] and a direction bit dir:
  - 0 ROTATE: seed 1. Rotate left by 1; the MSB wraps to bit 0.
  - 1 LFSR: seed all ones. pat <= {pat[W-2:0], fb}, where fb is the XOR of the maximal-length tap bits (for W=4, bits 3 and 2; period 2^W-1). If pat is ever 0, reload the seed.
  - 2 BLINK: seed all ones. Invert all bits.
  - 3 BOUNCE: seed 1, dir=left. Shift toward dir; the direction reverses when the lit bit reaches the MSB or bit 0. Period is 2(W-1).
  - 4 COUNT: seed 0. pat <= pat+1, wrapping mod 2^W.
  - 5, 6, 7 PASS: LED follows sw_db every cycle, zero-extended or truncated to LED_W. Patterns are ignored.
- LED <= (mode is PASS) ? sw_db : pat, registered every cycle.

## Timing
- Reset values: sync flops 0, sw_db 0, debounce counter 0, prescaler 0, mode 0, pat 1, dir left, LED 0.
- Reset mid-operation drops every output to its reset value immediately; no tick is needed.
- The first cycle after reset release shows LED = 0001 (W=4).
- Step latency: the state changes on the edge at which `tick` is high, and LED reflects it one edge later.
- Switch-to-sw_db latency: 2 + DEBOUNCE_CYCLES edges.
- In PASS mode, a SW change reaches LED in 3 + DEBOUNCE_CYCLES edges, with no wait for a tick.
- A mode change becomes visible (the seed on LED) one edge after the first tick following the sw_db update.
- Simultaneous events:
  - Tick with a mode change loads the seed; there is no extra step.
  - Tick while frozen leaves the state unchanged.
  - Freeze release takes effect on the next tick.
  - A switch change between PASS modes updates mode at the tick, while LED tracks sw_db throughout.

## Structure
- Package led_pattern_pkg holds:
  - enum mode_e: MODE_ROTATE=0, MODE_LFSR=1, MODE_BLINK=2, MODE_BOUNCE=3, MODE_COUNT=4, MODE_PASS0..2=5..7.
  - function lfsr_taps(width) returning the maximal-length tap mask for widths 2..16.
  - function is_pass(mode_e).
- Sub-module sw_debounce (parameter W, DEBOUNCE_CYCLES) contains the synchroniser and debouncer. Everything else stays in led_pattern_engine.

## Test plan
All scenarios use LED_W=4, TICK_DIV=4, DEBOUNCE_CYCLES=3.
- Reset and rotate: hold rst, then release with SW=0 -> LED=0000 during reset, then 0001; afterwards every 4 cycles 0010, 0100, 1000, 0001.
- Debounce plus bounce mode: 2-cycle glitches on SW to 0011 -> mode stays 0. Holding 0011 -> mode=3 at the next tick; LED runs 0001, 0010, 0100, 1000, 0100, 0010, 0001.
- LFSR: SW=0001 -> LED runs 1111, 1110, 1100, 1000, 0001, ...; back to 1111 after 15 ticks, never 0000.
- Freeze: SW=0100, count to 0101, then SW=1100 -> LED holds 0101 for 10 ticks. SW=0100 again -> next tick gives 0110.
- Passthrough: mode 5 active (SW=0101), change SW to 0110 -> LED=0110 exactly 6 edges later; mode=6 at the following tick.
- Async reset mid-run: in mode 4, assert rst between edges -> LED=0000 and mode=0 with no clock edge. Release -> 0001, rotating.

Source files
------------

// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_pkg
// Purpose  : Shared types and helpers for the LED pattern engine: the mode
//            encoding, the bounce direction type, the maximal-length LFSR
//            tap table and the passthrough-mode predicate.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_ROTATE = 3'd0,
        MODE_LFSR   = 3'd1,
        MODE_BLINK  = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_COUNT  = 3'd4,
        MODE_PASS0  = 3'd5,
        MODE_PASS1  = 3'd6,
        MODE_PASS2  = 3'd7
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Feedback mask for a shift-left Fibonacci LFSR; bit n set means pattern
    // bit n joins the XOR. Every entry gives a 2^width-1 period.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic is_pass(input mode_e m);
        return (m == MODE_PASS0) || (m == MODE_PASS1) || (m == MODE_PASS2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : Two-flop synchroniser followed by a debouncer. The debounced
//            value takes the synchronised value once the two have differed
//            for DEBOUNCE_CYCLES consecutive cycles; agreement restarts the
//            count.
// Ports    : clk   - system clock
//            rst   - asynchronous active-high reset
//            sw    - raw asynchronous switch inputs [W-1:0]
//            sw_db - synchronised, debounced switches [W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce
    import led_pattern_pkg::*;
#(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    output logic [W-1:0] sw_db
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]       r_meta;
    logic [W-1:0]       r_sync;
    logic [W-1:0]       r_db;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_db   <= '0;
            r_cnt  <= '0;
        end else begin
            r_meta <= sw;
            r_sync <= r_meta;
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign sw_db = r_db;

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_engine
// Purpose  : Turns slide switches into an LED animation. Switches are
//            debounced, a prescaler produces the step tick, and on each tick
//            either a new mode is adopted (loading its seed) or the current
//            pattern advances unless frozen. Modes 5..7 pass the debounced
//            switches straight to the LEDs.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            SW   - SW[2:0] mode select, SW[3] freeze
//            LED  - registered LED drive [LED_W-1:0]
//            mode - currently active mode (debug)
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int LED_W           = 4,
    parameter int TICK_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       SW,
    output logic [LED_W-1:0] LED,
    output logic [2:0]       mode
);

    localparam int                c_div_w     = $clog2(TICK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TICK_DIV - 1);
    localparam logic [15:0]       c_taps_full = lfsr_taps(LED_W);
    localparam logic [LED_W-1:0]  c_taps      = c_taps_full[LED_W-1:0];

    logic [3:0]         w_sw_db;
    logic               w_tick;
    mode_e              w_sel;
    logic [LED_W-1:0]   w_seed;
    logic [LED_W-1:0]   w_step_pat;
    dir_e               w_step_dir;

    logic [c_div_w-1:0] r_div;
    mode_e              r_mode;
    logic [LED_W-1:0]   r_pat;
    dir_e               r_dir;
    logic [LED_W-1:0]   r_led;

    sw_debounce #(
        .W               (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk   (clk),
        .rst   (rst),
        .sw    (SW),
        .sw_db (w_sw_db)
    );

    assign w_tick = (r_div == c_div_last);
    assign w_sel  = mode_e'(w_sw_db[2:0]);

    // Seed for the mode being entered.
    always_comb begin
        w_seed = LED_W'(1);
        case (w_sel)
            MODE_LFSR, MODE_BLINK: w_seed = '1;
            MODE_COUNT:            w_seed = '0;
            default:               w_seed = LED_W'(1);
        endcase
    end

    // One animation step of the current mode.
    always_comb begin
        w_step_pat = r_pat;
        w_step_dir = r_dir;
        case (r_mode)
            MODE_ROTATE: w_step_pat = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
            MODE_LFSR: begin
                // The all-zero state is a lock-up point; escape to the seed.
                if (r_pat == '0) begin
                    w_step_pat = '1;
                end else begin
                    w_step_pat = {r_pat[LED_W-2:0], ^(r_pat & c_taps)};
                end
            end
            MODE_BLINK: w_step_pat = ~r_pat;
            MODE_BOUNCE: begin
                // Turn around on the step that leaves an end position.
                if (r_dir == DIR_LEFT) begin
                    if (r_pat[LED_W-1]) begin
                        w_step_pat = r_pat >> 1;
                        w_step_dir = DIR_RIGHT;
                    end else begin
                        w_step_pat = r_pat << 1;
                    end
                end else begin
                    if (r_pat[0]) begin
                        w_step_pat = r_pat << 1;
                        w_step_dir = DIR_LEFT;
                    end else begin
                        w_step_pat = r_pat >> 1;
                    end
                end
            end
            MODE_COUNT: w_step_pat = r_pat + LED_W'(1);
            default:    w_step_pat = r_pat;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_mode <= MODE_ROTATE;
            r_pat  <= LED_W'(1);
            r_dir  <= DIR_LEFT;
            r_led  <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + c_div_w'(1);
            r_led <= is_pass(r_mode) ? LED_W'(w_sw_db) : r_pat;
            if (w_tick) begin
                // A mode change wins over both stepping and freeze.
                if (w_sel != r_mode) begin
                    r_mode <= w_sel;
                    r_pat  <= w_seed;
                    r_dir  <= DIR_LEFT;
                end else if (!w_sw_db[3]) begin
                    r_pat  <= w_step_pat;
                    r_dir  <= w_step_dir;
                end
            end
        end
    end

    assign LED  = r_led;
    assign mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_engine
// Purpose  : Self-checking bench for led_pattern_engine with LED_W=4,
//            TICK_DIV=4, DEBOUNCE_CYCLES=3. A behavioural model derives the
//            expected LED/mode from the step count since the last mode entry
//            and per-mode sequence tables; directed scenarios pin literal
//            values, then randomized switch activity runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int DC = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   SW  = 4'h0;
    logic [W-1:0] LED;
    logic [2:0]   mode;

    int checks = 0;
    int errors = 0;

    led_pattern_engine #(
        .LED_W           (W),
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .SW   (SW),
        .LED  (LED),
        .mode (mode)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] lfsr_seq   [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                    4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
    logic [3:0] bounce_seq [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};

    logic [3:0] hist0 = 4'h0;   // SW seen one edge ago
    logic [3:0] hist1 = 4'h0;   // SW seen two edges ago
    logic [3:0] m_db  = 4'h0;
    int         run   = 0;      // consecutive cycles hist1 differs from m_db
    int         cyc   = 0;      // edges since reset
    logic [2:0] m_mode = 3'd0;
    int         m_k   = 0;      // steps taken since the mode was entered
    logic [3:0] m_led = 4'h0;

    function automatic logic [3:0] pattern(input logic [2:0] m, input int k);
        case (m)
            3'd0:    return 4'(1 << (k % 4));
            3'd1:    return lfsr_seq[k % 15];
            3'd2:    return (k % 2 == 0) ? 4'hF : 4'h0;
            3'd3:    return bounce_seq[k % 6];
            3'd4:    return 4'(k % 16);
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist0  <= 4'h0;
            hist1  <= 4'h0;
            m_db   <= 4'h0;
            run    <= 0;
            cyc    <= 0;
            m_mode <= 3'd0;
            m_k    <= 0;
            m_led  <= 4'h0;
        end else begin
            m_led <= (m_mode >= 3'd5) ? m_db : pattern(m_mode, m_k);
            if (cyc % TD == TD - 1) begin
                if (m_db[2:0] != m_mode) begin
                    m_mode <= m_db[2:0];
                    m_k    <= 0;
                end else if (!m_db[3]) begin
                    m_k <= m_k + 1;
                end
            end
            cyc <= cyc + 1;
            if (hist1 == m_db) begin
                run <= 0;
            end else if (run + 1 == DC) begin
                m_db <= hist1;
                run  <= 0;
            end else begin
                run <= run + 1;
            end
            hist1 <= hist0;
            hist0 <= SW;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_led", 8'(LED), 8'(m_led));
        check("model_mode", 8'(mode), 8'(m_mode));
    end

    task automatic wait_mode(input logic [2:0] m);
        int n = 0;
        while (mode !== m && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_mode", 8'(mode), 8'(m));
    endtask

    task automatic wait_led(input logic [3:0] v);
        int n = 0;
        while (LED !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_led", 8'(LED), 8'(v));
    endtask

    // Checks LED against a literal sequence, one entry per tick, starting
    // on the negedge after the mode changed.
    task automatic check_seq(input string name, input logic [3:0] seq [], input int n);
        for (int i = 0; i < n; i++) begin
            repeat ((i == 0) ? 1 : TD) @(negedge clk);
            check(name, 8'(LED), 8'(seq[i]));
        end
    endtask

    logic [3:0] rot_exp    [] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] bounce_exp [] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
    logic [3:0] lfsr_exp   [] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9};

    initial begin
        // Reset and rotate
        rst = 1'b1;
        SW  = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_led", 8'(LED), 8'h00);
        check("reset_mode", 8'(mode), 8'h00);
        rst = 1'b0;
        check_seq("rotate", rot_exp, 5);

        // Short glitches must not reach the mode
        repeat (2) begin
            SW = 4'h3;
            repeat (2) @(negedge clk);
            SW = 4'h0;
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("glitch_mode", 8'(mode), 8'h00);

        // Bounce
        SW = 4'h3;
        wait_mode(3'd3);
        check_seq("bounce", bounce_exp, 7);

        // LFSR, then run past a full period
        SW = 4'h1;
        wait_mode(3'd1);
        check_seq("lfsr", lfsr_exp, 8);
        repeat (TD * 30) @(negedge clk);

        // Freeze at 0101 in count mode
        SW = 4'h4;
        wait_mode(3'd4);
        wait_led(4'h4);
        SW = 4'hC;
        repeat (TD * 10) @(negedge clk);
        check("freeze_hold", 8'(LED), 8'h05);
        check("freeze_mode", 8'(mode), 8'h04);
        SW = 4'h4;
        wait_led(4'h6);

        // Passthrough latency
        SW = 4'h5;
        wait_mode(3'd5);
        repeat (3) @(negedge clk);
        SW = 4'h6;
        repeat (5) @(negedge clk);
        check("pass_before", 8'(LED), 8'h05);
        @(negedge clk);
        check("pass_latency", 8'(LED), 8'h06);
        check("pass_mode_old", 8'(mode), 8'h05);
        wait_mode(3'd6);

        // Asynchronous reset mid-run
        SW = 4'h4;
        wait_mode(3'd4);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_led", 8'(LED), 8'h00);
        check("async_mode", 8'(mode), 8'h00);
        SW = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        check_seq("post_reset_rotate", rot_exp, 3);

        // Randomized switch activity against the model
        for (int i = 0; i < 200; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) v[3] = 1'b0;
            SW = v;
            repeat ($urandom_range(1, 14)) @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
